// File: rtl/image_write_sched.sv
// Job scheduler for image_write: queues descriptors, programs IMG_W/START/STEP, then pulses next.
// Optional flush port and queue flush under IW_SCHED_FLUSH_EN.
module image_write_sched #(
    parameter int CFG_DWIDTH   = 32,
    parameter int CFG_AWIDTH   = 5,
    parameter int CFG_IW_IMG_W = 1,
    parameter int CFG_IW_START = 2,
    parameter int CFG_IW_STEP  = 3,
    parameter int JOB_DEPTH    = 4,
    parameter int JOB_AWIDTH   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [79:0]           job_bus,
    input  logic                  job_val,
    output logic                  job_rdy,
    output logic [CFG_DWIDTH-1:0] cfg_data,
    output logic [CFG_AWIDTH-1:0] cfg_addr,
    output logic                  cfg_valid,
    output logic                  next,
    input  logic                  next_rdy,
`ifdef IW_SCHED_FLUSH_EN
    input  logic                  flush,
`endif
    output logic                  busy,
    output logic [JOB_AWIDTH:0]   job_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CFG_W,
        S_CFG_S,
        S_CFG_P,
        S_NEXT,
        S_GAP
    } state_t;

    localparam logic [JOB_AWIDTH:0]   CNT_ONE  = 1;
    localparam logic [JOB_AWIDTH:0]   CNT_FULL = (JOB_AWIDTH+1)'(JOB_DEPTH);
    localparam logic [JOB_AWIDTH-1:0] PTR_ONE  = 1;

    state_t                state;
    logic [79:0]           mem [JOB_DEPTH];
    logic [79:0]           hold;
    logic [79:0]           head;
    logic [JOB_AWIDTH-1:0] wr_ptr;
    logic [JOB_AWIDTH-1:0] rd_ptr;
    logic [JOB_AWIDTH:0]   cnt_nxt;
    logic                  flush_i;
    logic                  pop_ok;
    logic                  push;
    logic                  pop;
    logic                  start;

`ifdef IW_SCHED_FLUSH_EN
    assign flush_i = flush;
`else
    assign flush_i = 1'b0;
    assign pop_ok  = 1'b1;
`endif

    assign head  = mem[rd_ptr];
    assign push  = job_val & job_rdy & ~flush_i;
    assign pop   = (state == S_NEXT) & pop_ok;
    assign start = (job_cnt != '0) & next_rdy & ~flush_i;

    always_comb begin
        cnt_nxt = job_cnt;
        if (flush_i)
            cnt_nxt = '0;
        else if (push && !pop)
            cnt_nxt = job_cnt + CNT_ONE;
        else if (pop && !push)
            cnt_nxt = job_cnt - CNT_ONE;
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= job_bus;
    end

    // Flush empties by snapping the read pointer onto the write pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            job_cnt <= '0;
            job_rdy <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (flush_i)
                rd_ptr <= wr_ptr;
            else if (pop)
                rd_ptr <= rd_ptr + PTR_ONE;
            job_cnt <= cnt_nxt;
            job_rdy <= (cnt_nxt < CNT_FULL);
        end
    end

    // GAP resamples next_rdy itself, so back-to-back jobs run every 5 cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            hold      <= '0;
            cfg_valid <= 1'b0;
            cfg_addr  <= '0;
            cfg_data  <= '0;
            next      <= 1'b0;
            busy      <= 1'b0;
`ifdef IW_SCHED_FLUSH_EN
            pop_ok    <= 1'b0;
`endif
        end else begin
            cfg_valid <= 1'b0;
            cfg_addr  <= '0;
            cfg_data  <= '0;
            next      <= 1'b0;
            busy      <= 1'b1;
            unique case (state)
                S_IDLE, S_GAP: begin
                    if (start) begin
                        state     <= S_CFG_W;
                        hold      <= head;
                        cfg_valid <= 1'b1;
                        cfg_addr  <= CFG_AWIDTH'(CFG_IW_IMG_W);
                        cfg_data  <= {16'd0, head[15:0]};
`ifdef IW_SCHED_FLUSH_EN
                        pop_ok    <= 1'b1;
`endif
                    end else begin
                        state <= S_IDLE;
                        busy  <= (cnt_nxt != '0);
                    end
                end
                S_CFG_W: begin
                    state     <= S_CFG_S;
                    cfg_valid <= 1'b1;
                    cfg_addr  <= CFG_AWIDTH'(CFG_IW_START);
                    cfg_data  <= {hold[47:32], hold[31:16]};
                end
                S_CFG_S: begin
                    state     <= S_CFG_P;
                    cfg_valid <= 1'b1;
                    cfg_addr  <= CFG_AWIDTH'(CFG_IW_STEP);
                    cfg_data  <= {hold[79:64], hold[63:48]};
                end
                S_CFG_P: begin
                    state <= S_NEXT;
                    next  <= 1'b1;
                end
                S_NEXT: begin
                    state <= S_GAP;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= (cnt_nxt != '0);
                end
            endcase
`ifdef IW_SCHED_FLUSH_EN
            if (flush_i)
                pop_ok <= 1'b0;
`endif
        end
    end

endmodule
